if_id_reg: RTL

- IF/ID pipeline register directly downstream of the fetch stage.
- Captures the fetched instruction, its PC, its PC+4 and the branch-prediction sideband (is_branch, T_NT, hit) for decode.
- Supports stall (hold), misprediction flush, and a multi-cycle bubble train when the NPU double-matrix rollback fires.
- Pre-decodes the RISC-V register and function fields for the ID stage, and keeps saturating flush/stall event counters for debug.

---
 rtl/if_id_reg.sv | 133 +++++++++++++
 1 files changed

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall, flush and NPU rollback bubble train,
// plus RISC-V field pre-decode and saturating flush/stall debug counters.
module if_id_reg #(
  parameter logic [31:0] NOP_INST         = 32'h0000_0013,
  parameter int unsigned ROLLBACK_BUBBLES = 2,
  parameter int unsigned CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc_4,
  input  logic             if_is_branch,
  input  logic             if_t_nt,
  input  logic             if_hit,
  input  logic             IF_IDWrite,
  input  logic             flush,
  input  logic             double_matr,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc_4,
  output logic             id_is_branch,
  output logic             id_t_nt,
  output logic             id_hit,
  output logic [6:0]       id_opcode,
  output logic [4:0]       id_rd,
  output logic [2:0]       id_funct3,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic [6:0]       id_funct7,
  output logic             bubble_active,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  localparam logic [3:0] BCNT_INIT = 4'(ROLLBACK_BUBBLES - 1);

  state_t     state, state_n;
  logic [3:0] bcnt, bcnt_n;
  logic       load_bubble, load_fetch, flush_inc, stall_inc;

  always_comb begin
    state_n     = state;
    bcnt_n      = bcnt;
    load_bubble = 1'b0;
    load_fetch  = 1'b0;
    flush_inc   = 1'b0;
    stall_inc   = 1'b0;
    if (flush) begin
      load_bubble = 1'b1;
      bcnt_n      = '0;
      state_n     = RUN;
      flush_inc   = 1'b1;
    end else if (double_matr) begin
      load_bubble = 1'b1;
      bcnt_n      = BCNT_INIT;
      state_n     = (BCNT_INIT != '0) ? BUBBLE : RUN;
    end else if (state == BUBBLE) begin
      load_bubble = 1'b1;
      bcnt_n      = bcnt - 4'd1;
      state_n     = (bcnt_n == '0) ? RUN : BUBBLE;
    end else if (!IF_IDWrite) begin
      stall_inc   = 1'b1;
    end else begin
      load_fetch  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_inst      <= NOP_INST;
      id_pc_4      <= '0;
      id_is_branch <= 1'b0;
      id_t_nt      <= 1'b0;
      id_hit       <= 1'b0;
    end else if (load_bubble) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_inst      <= NOP_INST;
      id_pc_4      <= '0;
      id_is_branch <= 1'b0;
      id_t_nt      <= 1'b0;
      id_hit       <= 1'b0;
    end else if (load_fetch) begin
      id_valid     <= 1'b1;
      id_pc        <= if_pc;
      id_inst      <= if_inst;
      id_pc_4      <= if_pc_4;
      id_is_branch <= if_is_branch;
      id_t_nt      <= if_t_nt;
      id_hit       <= if_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    bubble_active = (state == BUBBLE);
    id_opcode     = id_inst[6:0];
    id_rd         = id_inst[11:7];
    id_funct3     = id_inst[14:12];
    id_rs1        = id_inst[19:15];
    id_rs2        = id_inst[24:20];
    id_funct7     = id_inst[31:25];
  end

endmodule
